// File: rtl/time_surface_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | time_surface_scan_ctrl: sweeps the 16x16 time-surface read port and      |
// | streams (addr,value) with credit backpressure; optional TS_SCAN_ZERO_SKIP_EN |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module time_surface_scan_ctrl #(
  parameter int ADDR_BITS     = 8,
  parameter int VALUE_BITS    = 8,
  parameter int TS_BITS       = 16,
  parameter int RD_LATENCY    = 2,
  parameter int FIFO_DEPTH    = 4,
  parameter int ACTIVE_THRESH = 16,
  parameter int AUTO_PERIOD   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [TS_BITS-1:0]    t_now,
  output logic [TS_BITS-1:0]    scan_t_now,
  output logic                  mem_read_enable,
  output logic [ADDR_BITS-1:0]  mem_read_addr,
  input  logic [VALUE_BITS-1:0] mem_read_value,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_BITS-1:0]  out_addr,
  output logic [VALUE_BITS-1:0] out_value,
  output logic                  busy,
  output logic                  frame_done,
  output logic [15:0]           frame_sum,
  output logic [8:0]            active_count,
  output logic [7:0]            overrun_count
);

  localparam int c_PW = $clog2(FIFO_DEPTH);
  localparam int c_CW = c_PW + 1;
  localparam logic [c_CW:0]        c_DEPTH     = (c_CW + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_BITS-1:0] c_LAST_ADDR = '1;
  localparam logic [ADDR_BITS:0]   c_CELLS     = {1'b1, {ADDR_BITS{1'b0}}};
  localparam logic [VALUE_BITS-1:0] c_THRESH   = VALUE_BITS'(ACTIVE_THRESH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  logic                  w_auto_tick, w_trig, w_accept, w_issue, w_credit, w_enter_done;
  logic [ADDR_BITS-1:0]  r_issue_idx;
  logic [TS_BITS-1:0]    r_scan_t;
  logic [RD_LATENCY-1:0] r_pipe_v;
  logic [ADDR_BITS-1:0]  r_pipe_a [RD_LATENCY];
  logic                  w_cap, w_in_v, w_push, w_pop, w_deq, w_empty;
  logic [ADDR_BITS-1:0]  w_cap_addr;
  logic [c_CW-1:0]       r_inflight, r_fcnt, w_fcnt_nxt;
  logic [c_PW-1:0]       r_wp, r_rp;
  logic [ADDR_BITS-1:0]  r_fa [FIFO_DEPTH];
  logic [VALUE_BITS-1:0] r_fv [FIFO_DEPTH];
  logic [15:0]           r_sum, w_sum_nxt, r_frame_sum;
  logic [8:0]            r_act, w_act_nxt, r_active;
  logic [ADDR_BITS:0]    r_ret, w_ret_nxt;
  logic [7:0]            r_overrun;

  generate
    if (AUTO_PERIOD != 0) begin : g_auto
      localparam int c_AW = $clog2(AUTO_PERIOD + 1);
      localparam logic [c_AW-1:0] c_AMAX = c_AW'(AUTO_PERIOD - 1);
      logic [c_AW-1:0] r_auto_cnt;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     r_auto_cnt <= '0;
        else if (r_auto_cnt == c_AMAX)  r_auto_cnt <= '0;
        else                            r_auto_cnt <= r_auto_cnt + 1'b1;
      end
      assign w_auto_tick = (r_auto_cnt == c_AMAX);
    end else begin : g_no_auto
      assign w_auto_tick = 1'b0;
    end
  endgenerate

  assign w_trig     = start | w_auto_tick;
  assign w_accept   = w_trig && (r_state == S_IDLE);
  assign w_credit   = ({1'b0, r_fcnt} + {1'b0, r_inflight}) < c_DEPTH;
  assign w_cap      = r_pipe_v[RD_LATENCY-1];
  assign w_cap_addr = r_pipe_a[RD_LATENCY-1];

`ifdef TS_SCAN_ZERO_SKIP_EN
  assign w_in_v = w_cap && (mem_read_value != '0);
`else
  assign w_in_v = w_cap;
`endif

  // Empty FIFO bypasses the returning value straight to the stream; a stalled bypass is pushed.
  assign w_empty    = (r_fcnt == '0);
  assign out_valid  = !w_empty || w_in_v;
  assign out_addr   = !w_empty ? r_fa[r_rp] : (w_in_v ? w_cap_addr : '0);
  assign out_value  = !w_empty ? r_fv[r_rp] : (w_in_v ? mem_read_value : '0);
  assign w_pop      = out_valid && out_ready;
  assign w_push     = w_in_v && !(w_empty && out_ready);
  assign w_deq      = w_pop && !w_empty;
  assign w_fcnt_nxt = r_fcnt + c_CW'(w_push) - c_CW'(w_deq);

  assign w_sum_nxt  = w_cap ? r_sum + 16'(mem_read_value) : r_sum;
  assign w_act_nxt  = (w_cap && (mem_read_value >= c_THRESH)) ? r_act + 9'd1 : r_act;
  assign w_ret_nxt  = w_cap ? r_ret + 1'b1 : r_ret;

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE:  if (w_trig) w_state_nxt = S_ISSUE;
      S_ISSUE: if (w_credit) begin
        w_issue = 1'b1;
        if (r_issue_idx == c_LAST_ADDR) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: if ((w_ret_nxt == c_CELLS) && (w_fcnt_nxt == '0)) w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_enter_done = (r_state == S_DRAIN) && (w_state_nxt == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_issue_idx <= '0;
      r_scan_t    <= '0;
      r_pipe_v    <= '0;
      for (int i = 0; i < RD_LATENCY; i++) r_pipe_a[i] <= '0;
      r_inflight  <= '0;
      r_fcnt      <= '0;
      r_wp        <= '0;
      r_rp        <= '0;
      r_sum       <= '0;
      r_act       <= '0;
      r_ret       <= '0;
      r_frame_sum <= '0;
      r_active    <= '0;
      r_overrun   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pipe_v   <= RD_LATENCY'({r_pipe_v, w_issue});
      r_pipe_a[0] <= r_issue_idx;
      for (int i = 1; i < RD_LATENCY; i++) r_pipe_a[i] <= r_pipe_a[i-1];
      r_inflight <= r_inflight + c_CW'(w_issue) - c_CW'(w_cap);
      r_fcnt     <= w_fcnt_nxt;
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_deq)  r_rp <= r_rp + 1'b1;
      if (w_accept) begin
        r_scan_t    <= t_now;
        r_issue_idx <= '0;
        r_sum       <= '0;
        r_act       <= '0;
        r_ret       <= '0;
      end else begin
        if (w_issue) r_issue_idx <= r_issue_idx + 1'b1;
        r_sum <= w_sum_nxt;
        r_act <= w_act_nxt;
        r_ret <= w_ret_nxt;
      end
      if (w_enter_done) begin
        r_frame_sum <= w_sum_nxt;
        r_active    <= w_act_nxt;
      end
      if (w_trig && (r_state != S_IDLE) && (r_overrun != 8'hFF))
        r_overrun <= r_overrun + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fa[r_wp] <= w_cap_addr;
      r_fv[r_wp] <= mem_read_value;
    end
  end

  assign scan_t_now      = r_scan_t;
  assign mem_read_addr   = r_issue_idx;
  assign mem_read_enable = r_pipe_v[0];
  assign busy            = (r_state != S_IDLE);
  assign frame_done      = (r_state == S_DONE);
  assign frame_sum       = r_frame_sum;
  assign active_count    = r_active;
  assign overrun_count   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_time_surface_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_time_surface_scan_ctrl: scoreboard bench for the scan sequencer       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_time_surface_scan_ctrl;

  logic        clk = 1'b0, rst_n = 1'b0, rst_a_n = 1'b0;
  logic        start = 1'b0, start_a = 1'b0, out_ready = 1'b0;
  logic [15:0] t_now = 16'h1234;

  logic [15:0] scan_t_now, a_scan_t_now, frame_sum, a_frame_sum;
  logic        mem_read_enable, a_mem_read_enable, out_valid, a_out_valid;
  logic [7:0]  mem_read_addr, a_mem_read_addr, out_addr, a_out_addr, out_value, a_out_value;
  logic        busy, a_busy, frame_done, a_frame_done;
  logic [8:0]  active_count, a_active_count;
  logic [7:0]  overrun_count, a_overrun_count;
  logic [7:0]  mem_a1 = 8'd0, mem_v = 8'd0, mema_a1 = 8'd0, mema_v = 8'd0;

  time_surface_scan_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .t_now(t_now), .scan_t_now(scan_t_now),
    .mem_read_enable(mem_read_enable), .mem_read_addr(mem_read_addr), .mem_read_value(mem_v),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_value(out_value),
    .busy(busy), .frame_done(frame_done), .frame_sum(frame_sum),
    .active_count(active_count), .overrun_count(overrun_count));

  time_surface_scan_ctrl #(.AUTO_PERIOD(400)) dut_a (
    .clk(clk), .rst_n(rst_a_n), .start(start_a), .t_now(t_now), .scan_t_now(a_scan_t_now),
    .mem_read_enable(a_mem_read_enable), .mem_read_addr(a_mem_read_addr), .mem_read_value(mema_v),
    .out_valid(a_out_valid), .out_ready(1'b1), .out_addr(a_out_addr), .out_value(a_out_value),
    .busy(a_busy), .frame_done(a_frame_done), .frame_sum(a_frame_sum),
    .active_count(a_active_count), .overrun_count(a_overrun_count));

  always #5 clk = ~clk;

  int unsigned fsel = 0;

  function automatic logic [7:0] fval(int unsigned sel, logic [7:0] a);
    case (sel)
      0: return a;
      1: return a & 8'h0F;
      2: return 8'd16;
      3: return 8'hFF;
      4: return a ^ 8'h5A;
      5: return (a == 8'd5) ? 8'd200 : ((a == 8'd77) ? 8'd10 : 8'd0);
      default: return 8'd0;
    endcase
  endfunction

  // Memory models: address registered, value computed while read_enable is high.
  always @(posedge clk) begin
    mem_a1 <= mem_read_addr;
    if (mem_read_enable) mem_v <= fval(fsel, mem_a1);
    mema_a1 <= a_mem_read_addr;
    if (a_mem_read_enable) mema_v <= fval(0, mema_a1);
  end

  typedef struct packed { logic [7:0] a; logic [7:0] v; } el_t;
  typedef struct { int sel; int rmode; int exp_sum; int exp_act; int exp_done; } vec_t;

  el_t  q[$];
  vec_t vecs[7];
  int   n_vec = 0, n_bad = 0;
  int   cyc = 0, rmode = 0, n_en = 0, n_acc = 0, done_cyc = -1, first_v = -1, exp_first = 0;
  int   a_done_n = 0, a_last_done = 0;
  logic prev_stall = 1'b0, a_check_period = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    case (rmode)
      0:       out_ready = 1'b1;
      1:       out_ready = (cyc % 4 == 0);
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    if (prev_stall) check("stall_valid_held", 32'(out_valid), 1);
    if (mem_read_enable) begin
      n_en++;
      check("credit_limit", 32'((n_en - n_acc) <= 4), 1);
    end
    if (out_valid) begin
      if (first_v < 0) first_v = cyc;
      if (q.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL unexpected_element: got addr %0d required none", out_addr);
      end else begin
        check("out_addr", 32'(out_addr), 32'(q[0].a));
        check("out_value", 32'(out_value), 32'(q[0].v));
        if (out_ready) begin void'(q.pop_front()); n_acc++; end
      end
    end
    if (frame_done) done_cyc = cyc;
    prev_stall = out_valid && !out_ready;
    if (a_frame_done) begin
      a_done_n++;
      check("auto_frame_sum", 32'(a_frame_sum), 32640);
      check("auto_active", 32'(a_active_count), 240);
      if (a_check_period && a_last_done > 0) check("auto_period", cyc - a_last_done, 400);
      a_last_done = cyc;
    end
    t_now = t_now + 16'd3;
  endtask

  task automatic load_expected(int sel);
    logic [7:0] v;
    q.delete();
    n_en = 0; n_acc = 0; done_cyc = -1; first_v = -1; prev_stall = 1'b0;
    for (int a = 0; a < 256; a++) begin
      v = fval(sel, 8'(a));
`ifdef TS_SCAN_ZERO_SKIP_EN
      if (v != 8'd0)
`endif
        q.push_back('{a: 8'(a), v: v});
    end
    exp_first = (q.size() > 0) ? 3 + int'(q[0].a) : -1;
  endtask

  task automatic run_frame(vec_t vv);
    int c0;
    logic [15:0] t0;
    fsel = vv.sel; rmode = vv.rmode;
    load_expected(vv.sel);
    step();
    start = 1'b1; t0 = t_now; c0 = cyc;
    step();
    start = 1'b0;
    for (int k = 0; k < 3000 && done_cyc < 0; k++) step();
    check("frame_done_seen", 32'(done_cyc >= 0), 1);
    if (vv.exp_done >= 0) begin
      check("done_latency", done_cyc - c0, vv.exp_done);
      check("first_valid_latency", first_v - c0, exp_first);
    end
    check("frame_sum", 32'(frame_sum), vv.exp_sum);
    check("active_count", 32'(active_count), vv.exp_act);
    check("stream_leftover", q.size(), 0);
    check("scan_t_now_frozen", 32'(scan_t_now), 32'(t0));
    step();
    check("busy_cleared", 32'(busy), 0);
    check("frame_done_pulse", 32'(frame_done), 0);
  endtask

  initial begin
    int c0, n0;
    logic [15:0] ta0;
    vecs[0] = '{0, 0, 32640, 240, 259};
    vecs[1] = '{0, 1, 32640, 240, -1};
    vecs[2] = '{1, 0, 1920, 0, 259};
    vecs[3] = '{2, 2, 4096, 256, -1};
    vecs[4] = '{3, 0, 65280, 256, 259};
    vecs[5] = '{4, 2, 32640, 240, -1};
    vecs[6] = '{5, 1, 210, 1, -1};

    repeat (3) step();
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_mem_en", 32'(mem_read_enable), 0);
    check("rst_mem_addr", 32'(mem_read_addr), 0);
    check("rst_scan_t", 32'(scan_t_now), 0);
    check("rst_frame_sum", 32'(frame_sum), 0);
    check("rst_active", 32'(active_count), 0);
    check("rst_overrun", 32'(overrun_count), 0);
    check("rst_a_busy", 32'(a_busy), 0);
    rst_n = 1'b1; rst_a_n = 1'b1;
    a_check_period = 1'b1;

    for (int i = 0; i < 7; i++) run_frame(vecs[i]);
    check("auto_overrun_zero", 32'(a_overrun_count), 0);
    check("auto_frames_seen", 32'(a_done_n >= 3), 1);

    // Three starts while busy on the manual-only instance.
    fsel = 0; rmode = 0;
    load_expected(0);
    step();
    start = 1'b1; c0 = cyc;
    step();
    start = 1'b0;
    for (int k = 0; k < 600 && done_cyc < 0; k++) begin
      step();
      start = (cyc - c0 == 20) || (cyc - c0 == 50) || (cyc - c0 == 90);
    end
    start = 1'b0;
    check("overrun_manual", 32'(overrun_count), 3);
    check("overrun_done_latency", done_cyc - c0, 259);
    check("overrun_frame_sum", 32'(frame_sum), 32640);

    // Reset in the middle of a scan.
    load_expected(0);
    step();
    start = 1'b1; c0 = cyc;
    step();
    start = 1'b0;
    while (cyc - c0 < 100) step();
    rst_n = 1'b0;
    prev_stall = 1'b0;
    #1;
    check("abort_valid", 32'(out_valid), 0);
    check("abort_addr", 32'(out_addr), 0);
    check("abort_value", 32'(out_value), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_mem_en", 32'(mem_read_enable), 0);
    check("abort_mem_addr", 32'(mem_read_addr), 0);
    check("abort_scan_t", 32'(scan_t_now), 0);
    check("abort_frame_sum", 32'(frame_sum), 0);
    check("abort_active", 32'(active_count), 0);
    check("abort_overrun", 32'(overrun_count), 0);
    q.delete();
    done_cyc = -1;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (3) step();
    check("abort_no_frame_done", 32'(done_cyc), 32'(-1));
    run_frame(vecs[0]);

    // Auto instance: manual start between auto frames, then 3 starts plus an auto tick while busy.
    n0 = a_done_n;
    for (int k = 0; k < 600 && a_done_n == n0; k++) step();
    check("auto_done_wait", 32'(a_done_n > n0), 1);
    a_check_period = 1'b0;
    repeat (5) step();
    start_a = 1'b1; ta0 = t_now; c0 = cyc; n0 = a_done_n;
    step();
    start_a = 1'b0;
    for (int k = 0; k < 600 && a_done_n == n0; k++) begin
      step();
      start_a = (cyc - c0 == 30) || (cyc - c0 == 60) || (cyc - c0 == 100);
    end
    start_a = 1'b0;
    check("auto_manual_latency", a_last_done - c0, 259);
    check("auto_overrun_four", 32'(a_overrun_count), 4);
    check("auto_scan_t_frozen", 32'(a_scan_t_now), 32'(ta0));
    a_last_done = 0;
    a_check_period = 1'b1;
    n0 = a_done_n;
    repeat (1000) step();
    check("auto_resumed", 32'(a_done_n - n0 >= 2), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
